// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller.
// Sizes, aligns and issues one memory op at a time, with a timeout abort.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata_aligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_off;
  logic        r_is_ld;
  logic        r_done;
  logic [1:0]  r_err;
  logic [31:0] r_rdata;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  logic        w_op_ld;
  logic        w_op_st;
  logic        w_take;
  logic [2:0]  w_f3;
  logic        w_f3_ok;
  logic        w_sz_b;
  logic        w_sz_h;
  logic        w_sz_w;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [CW-1:0] w_cnt_nx;
  logic        w_tmo;
  logic        w_unused;

  assign w_op_ld  = (inst[6:0] == 7'b0000011);
  assign w_op_st  = (inst[6:0] == 7'b0100011);
  assign w_f3     = inst[14:12];
  assign w_take   = start && (w_op_ld || w_op_st) &&
                    (r_state == S_IDLE || r_state == S_DONE);
  assign w_f3_ok  = w_op_ld ?
                    (w_f3 != 3'b011 && w_f3 != 3'b110 && w_f3 != 3'b111) :
                    (!w_f3[2] && w_f3[1:0] != 2'b11);
  assign w_sz_b   = (w_f3[1:0] == 2'b00);
  assign w_sz_h   = (w_f3[1:0] == 2'b01);
  assign w_sz_w   = (w_f3[1:0] == 2'b10);
  assign w_mis    = (w_sz_h && addr[0]) || (w_sz_w && (addr[1:0] != 2'b00));
  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_tmo    = (w_cnt_nx == CW'(TIMEOUT_CYC));
  assign w_unused = ^{inst[31:15], inst[11:7]};

  // Byte-enable and lane-replicated store data for the incoming op
  always_comb begin
    w_be = 4'b0000;
    w_wd = 32'h0;
    unique case (1'b1)
      w_sz_b: begin
        w_be = 4'b0001 << addr[1:0];
        w_wd = {4{wdata[7:0]}};
      end
      w_sz_h: begin
        w_be = 4'b0011 << addr[1:0];
        w_wd = {2{wdata[15:0]}};
      end
      w_sz_w: begin
        w_be = 4'b1111;
        w_wd = wdata;
      end
      default: begin
        w_be = 4'b0000;
        w_wd = 32'h0;
      end
    endcase
  end

  // Control FSM with registered memory-side and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_off   <= 2'b00;
      r_is_ld <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 2'b00;
      r_rdata <= 32'h0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_be    <= 4'b0000;
      r_wdata <= 32'h0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_take) begin
            r_cnt <= '0;
            if (!w_f3_ok) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 2'b10;
              r_rdata <= 32'h0;
            end else if (w_mis) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 2'b01;
              r_rdata <= 32'h0;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_we    <= w_op_st;
              r_addr  <= {addr[31:2], 2'b00};
              r_be    <= w_be;
              r_wdata <= w_op_st ? w_wd : 32'h0;
              r_is_ld <= w_op_ld;
              r_off   <= addr[1:0];
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          r_cnt <= w_cnt_nx;
          if (mem_gnt) begin
            r_req <= 1'b0;
            if (r_is_ld) begin
              r_state <= S_WAIT_R;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 2'b00;
            end
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 2'b11;
            r_rdata <= 32'h0;
          end
        end
        S_WAIT_R: begin
          r_cnt <= w_cnt_nx;
          if (mem_rvalid) begin
            r_rdata <= mem_rdata >> {r_off, 3'b000};
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 2'b00;
          end else if (w_tmo) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 2'b11;
            r_rdata <= 32'h0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = rst_n &&
                (r_state == S_REQ || r_state == S_WAIT_R || w_take);
  assign done          = r_done;
  assign err           = r_err;
  assign rdata_aligned = r_rdata;
  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_be        = r_be;
  assign mem_wdata     = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl.
// Directed and random load/store ops against a behavioural model.
module tb_mem_access_ctrl;

  localparam int TMO = 64;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_AL = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rdata_aligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [1:0]  exp_err = 2'b00;
  logic [31:0] exp_rd = 32'h0;

  mem_access_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .inst(inst),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .err(err),
    .rdata_aligned(rdata_aligned),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: error code from op class, funct3 and address
  function automatic logic [1:0] m_err(input bit isld, input logic [2:0] f3,
                                       input logic [31:0] a);
    int sz;
    bit legal;
    legal = isld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
    if (!legal) return 2'b10;
    sz = 1 << (f3 % 4);
    if ((a % sz) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int sz;
    int v;
    sz = 1 << (f3 % 4);
    v = ((1 << sz) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input bit isst, input logic [2:0] f3,
                                       input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    r = 32'h0;
    if (!isst) return r;
    sz = 1 << (f3 % 4);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = $urandom();
      tick();
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_err", err, exp_err);
      chk("idle_rdata", rdata_aligned, exp_rd);
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int gdly, input int rdly,
                       input logic [31:0] rd, input bit stray);
    logic [31:0] ins;
    bit isld;
    bit isst;
    logic [1:0] e;
    logic [3:0] be;
    logic [31:0] wexp;
    int total;
    int rv_c;
    ins = $urandom();
    ins[6:0] = op;
    ins[14:12] = f3;
    isld = (op == OP_LD);
    isst = (op == OP_ST);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    start = 1'b1;
    inst = ins;
    addr = a;
    wdata = wd;
    #1;
    chk("busy_acc", busy, 32'(isld || isst));
    tick();
    start = 1'b0;
    inst = $urandom();
    addr = $urandom();
    wdata = $urandom();
    if (!(isld || isst)) begin
      chk("nop_done", done, 0);
      chk("nop_busy", busy, 0);
      chk("nop_req", mem_req, 0);
      chk("nop_err", err, exp_err);
      return;
    end
    e = m_err(isld, f3, a);
    if (e != 2'b00) begin
      exp_err = e;
      exp_rd = 32'h0;
      chk("bad_done", done, 1);
      chk("bad_err", err, e);
      chk("bad_req", mem_req, 0);
      chk("bad_rdata", rdata_aligned, 0);
      return;
    end
    be = m_be(f3, a);
    wexp = m_wd(isst, f3, wd);
    rv_c = gdly + 1 + rdly;
    total = isst ? gdly + 1 : gdly + rdly + 2;
    if (total > TMO) begin
      total = TMO;
      exp_err = 2'b11;
      exp_rd = 32'h0;
    end else begin
      exp_err = 2'b00;
      if (isld) exp_rd = rd >> (8 * (a % 4));
    end
    for (int c = 0; c < total; c++) begin
      mem_gnt = (c == gdly);
      mem_rvalid = isld && ((c == rv_c) || (stray && c == gdly));
      mem_rdata = (c == rv_c) ? rd : $urandom();
      chk("op_done", done, 0);
      chk("op_busy", busy, 1);
      chk("op_req", mem_req, 32'(c <= gdly));
      if (c == 0 || c == gdly) begin
        chk("op_addr", mem_addr, {a[31:2], 2'b00});
        chk("op_be", mem_be, be);
        chk("op_we", mem_we, 32'(isst));
        chk("op_wdata", mem_wdata, wexp);
      end
      tick();
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    chk("end_done", done, 1);
    chk("end_err", err, exp_err);
    chk("end_req", mem_req, 0);
    chk("end_rdata", rdata_aligned, exp_rd);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata_aligned, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    tick();
    rst_n = 1'b1;

    // lb 0x1003: first op right after reset release
    do_op(OP_LD, 3'b000, 32'h1003, 32'h0, 0, 1, 32'hAABBCCDD, 0);
    chk("lb_val", rdata_aligned, 32'h000000AA);
    idle(2);

    // sh 0x2002
    do_op(OP_ST, 3'b001, 32'h2002, 32'h00001234, 0, 0, 32'h0, 0);
    idle(1);

    // misaligned lw, illegal load funct3
    do_op(OP_LD, 3'b010, 32'h3001, 32'h0, 0, 0, 32'h0, 0);
    idle(1);
    do_op(OP_LD, 3'b011, 32'h3000, 32'h0, 0, 0, 32'h0, 0);
    idle(1);

    // sw never granted: timeout
    do_op(OP_ST, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 1000, 0, 32'h0, 0);
    idle(1);

    // lbu then back-to-back lbu 0x4001 with stray rvalid in REQ
    do_op(OP_LD, 3'b100, 32'h4000, 32'h0, 1, 0, 32'h11223344, 1);
    do_op(OP_LD, 3'b100, 32'h4001, 32'h0, 0, 2, 32'h55667788, 1);
    chk("lbu_val", rdata_aligned, 32'h00556677);
    idle(1);

    // ALU opcode is ignored, err holds
    do_op(OP_AL, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    idle(1);

    // reset in WAIT_R abandons the op
    start = 1'b1;
    inst = {17'h0, 3'b010, 5'd1, OP_LD};
    addr = 32'h5000;
    tick();
    start = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    chk("mr_rdata", rdata_aligned, 0);
    chk("mr_req", mem_req, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_be", mem_be, 0);
    chk("mr_wdata", mem_wdata, 0);
    tick();
    rst_n = 1'b1;
    exp_err = 2'b00;
    exp_rd = 32'h0;
    idle(3);

    // random ops
    for (int k = 0; k < 60; k++) begin
      logic [6:0] op;
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      op = (r == 0) ? OP_AL : (r < 5) ? OP_LD : OP_ST;
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_op(op, 3'($urandom_range(0, 7)), a, $urandom(),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, max cycles an op may spend in REQ+WAIT_R before abort.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  pipeline issues memory op this cycle.
REQ-005 inst  input  32  instruction; opcode inst[6:0], funct3 inst[14:12].
REQ-006 addr  input  32  effective byte address.
REQ-007 wdata  input  32  store source (rs2).
REQ-008 busy  output  1  stall to pipeline.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with done.
REQ-011 rdata_aligned  output  32  load word right-shifted so addressed byte sits in [7:0]; feeds the load sign/zero-extend stage.
REQ-012 mem_req  output  1  memory request, held until mem_gnt.
REQ-013 mem_we  output  1  1 = store.
REQ-014 mem_addr  output  32  {addr[31:2],2'b00}.
REQ-015 mem_be  output  4  byte enables.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_gnt  input  1  request accepted.
REQ-018 mem_rvalid  input  1  read data valid.
REQ-019 mem_rdata  input  32  read data.

Function
REQ-020 FSM states IDLE, REQ, WAIT_R, DONE; start sampled only in IDLE or DONE.
REQ-021 start with opcode 0000011 (load) or 0100011 (store) latches inst, addr, wdata and clears timeout counter; other opcodes ignored (no done).
REQ-022 Legal funct3: load 000,001,010,100,101; store 000,001,010; else next state DONE, err=10, no mem_req.
REQ-023 Alignment: byte ops any addr; half ops addr[0]=0; word ops addr[1:0]=00; violation -> DONE, err=01, no mem_req; illegal funct3 takes priority.
REQ-024 Legal aligned op -> REQ; mem_req=1 with mem_addr, mem_be, mem_we, mem_wdata stable from latched values until mem_gnt.
REQ-025 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; same for loads and stores.
REQ-026 mem_wdata: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata; 0 for loads.
REQ-027 REQ & mem_gnt: store -> DONE; load -> WAIT_R; mem_req deasserts the cycle after gnt.
REQ-028 mem_rvalid honoured only in WAIT_R (earliest cycle after gnt); ignored in all other states.
REQ-029 WAIT_R & mem_rvalid: rdata_aligned <= mem_rdata >> (8*addr[1:0]), -> DONE, err=00.
REQ-030 rdata_aligned holds until next load completes; timeout or error leaves it 0.
REQ-031 busy=1 in REQ and WAIT_R, and the cycle start is accepted; 0 in IDLE and DONE.
REQ-032 DONE lasts exactly one cycle, done=1; then IDLE, or new op if start present (back-to-back).
REQ-033 Timeout counter increments each cycle in REQ/WAIT_R; reaching TIMEOUT_CYC -> DONE, err=11, mem_req dropped, rdata_aligned=0.
REQ-034 err holds its value until next done.

Reset
REQ-035 rst_n low asynchronously forces IDLE, counter 0, and all outputs 0 (busy, done, err, rdata_aligned, mem_req, mem_we, mem_addr, mem_be, mem_wdata).
REQ-036 Reset mid-op (REQ/WAIT_R) abandons the op with no done; later mem_rvalid ignored.
REQ-037 First start accepted on the first rising edge after rst_n deasserts.

Verification
REQ-038 lb addr 0x1003, gnt 1st cycle, rvalid 2 cycles later, rdata 0xAABBCCDD -> mem_be 1000, mem_addr 0x1000, rdata_aligned 0x000000AA, single done, err 00.
REQ-039 sh addr 0x2002, wdata 0x00001234, gnt immediate -> mem_we 1, mem_be 1100, mem_wdata 0x12341234, done next cycle, err 00.
REQ-040 lw addr 0x3001 -> no mem_req, done next cycle, err 01; load funct3 011 -> err 10.
REQ-041 sw, mem_gnt held low 64 cycles -> mem_req drops, done, err 11.
REQ-042 lw in WAIT_R, rst_n pulsed low -> all outputs 0 immediately, later rvalid produces no done.
REQ-043 start asserted in DONE cycle with lbu addr 0x4001 -> accepted without IDLE gap, mem_be 0010.
